// File: rtl/j_dsp_irq_pkg.sv
// Shared constants and types for the Jerry DSP interrupt arbiter.
// Flags register field positions, source indices and the sequencer states.
package j_dsp_irq_pkg;

  // Flags register field positions
  localparam int IMASK_BIT = 3;
  localparam int EN_LSB    = 4;
  localparam int CLR_LSB   = 10;

  // Interrupt source indices
  localparam int SRC_CPU  = 0;
  localparam int SRC_I2S  = 1;
  localparam int SRC_TIM1 = 2;
  localparam int SRC_TIM2 = 3;
  localparam int SRC_EXT0 = 4;
  localparam int SRC_EXT1 = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/j_irq_prio_enc.sv
// Combinational priority encoder over the pending interrupt vector.
// RR = 0: highest set index wins, start is ignored.
// RR = 1: ascending search beginning at start, wrapping past NSRC-1 to 0.
module j_irq_prio_enc #(
  parameter int NSRC = 6,
  parameter bit RR   = 1'b0,
  parameter int IW   = $clog2(NSRC)
) (
  input  logic [NSRC-1:0] pend,
  input  logic [IW-1:0]   start,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  int pos;

  // start only steers the search in round-robin mode
  logic unused_start;
  assign unused_start = ^start;

  // Pick the winning index; later loop iterations override earlier ones
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    valid = |pend;
    idx   = '0;
    pos   = 0;
    if (RR) begin
      // Walk offsets from farthest to nearest so the first hit after start wins
      for (int k = NSRC - 1; k >= 0; k--) begin
        pos = int'(start) + k;
        if (pos >= NSRC) pos = pos - NSRC;
        if (pend[pos]) idx = IW'(pos);
      end
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (pend[i]) idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/j_dsp_irq_arb.sv
// Jerry DSP interrupt arbiter/sequencer.
// Edge-detects and latches the interrupt sources, gates them with per-source
// enables, presents one winner with its vector and masks further interrupts
// until software clears IMASK through the flags register.
// Optional build macro J_DSP_IRQ_RR_PRIO_EN selects round-robin priority;
// without it the highest pending index wins.
module j_dsp_irq_arb
  import j_dsp_irq_pkg::*;
#(
  parameter int          NSRC     = 6,
  parameter logic [23:0] VEC_BASE = 24'hF1B000
) (
  input  logic            sys_clk,
  input  logic            reset,
  input  logic            go,
  input  logic [NSRC-1:0] irq_src,
  input  logic            flagwr,
  input  logic [31:0]     gpu_din,
  input  logic            flagrd,
  output logic [31:0]     flag_dout,
  output logic            irq_req,
  output logic [23:0]     irq_vec,
  input  logic            irq_ack,
  output logic            imask
);

  localparam int IW       = $clog2(NSRC);
  localparam int TOP_USED = CLR_LSB + NSRC;

  irq_state_t      state;
  logic [NSRC-1:0] src_d;
  logic [NSRC-1:0] latch;
  logic [NSRC-1:0] enable;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] flag_clr;
  logic [NSRC-1:0] ack_clr;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   start;
  logic            enc_valid;
  logic [IW-1:0]   enc_idx;
  logic            ack_take;

  // Flags write data bits with no register behind them
  logic unused_din;
  assign unused_din = ^{gpu_din[31:TOP_USED], gpu_din[IMASK_BIT-1:0]};

  assign rise     = irq_src & ~src_d;
  assign pend     = latch & enable;
  assign ack_take = (state == REQ) && irq_ack;
  assign flag_clr = flagwr ? gpu_din[CLR_LSB +: NSRC] : '0;
  assign ack_clr  = ack_take ? (NSRC'(1) << winner) : '0;

`ifdef J_DSP_IRQ_RR_PRIO_EN
  localparam bit RR_MODE = 1'b1;
  logic [IW-1:0] last_winner;

  // Remember the most recently serviced source; the search resumes just past it
  always_ff @(posedge sys_clk) begin
    if (reset) last_winner <= IW'(NSRC - 1);
    else if (ack_take) last_winner <= winner;
  end

  assign start = (last_winner == IW'(NSRC - 1)) ? '0 : last_winner + IW'(1);
`else
  localparam bit RR_MODE = 1'b0;
  assign start = '0;
`endif

  j_irq_prio_enc #(
    .NSRC (NSRC),
    .RR   (RR_MODE),
    .IW   (IW)
  ) u_prio_enc (
    .pend  (pend),
    .start (start),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  // Edge detect, source latches (clears beat new edges) and enable register
  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      src_d  <= '0;
      latch  <= '0;
      enable <= '0;
    end else begin
      src_d <= irq_src;
      latch <= (latch | rise) & ~(flag_clr | ack_clr);
      if (flagwr) enable <= gpu_din[EN_LSB +: NSRC];
    end
  end

  // Request/acknowledge/service sequencer with registered outputs
  always_ff @(posedge sys_clk) begin
    // NOTE: only control state is reset; winner is reset too since it drives ack_clr.
    if (reset) begin
      state   <= IDLE;
      irq_req <= 1'b0;
      imask   <= 1'b0;
      irq_vec <= VEC_BASE;
      winner  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go && enc_valid && !imask) begin
            winner  <= enc_idx;
            irq_vec <= VEC_BASE + (24'(enc_idx) << 4);
            irq_req <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          // A committed request survives enable changes; only ack or go low ends it
          if (irq_ack) begin
            irq_req <= 1'b0;
            imask   <= 1'b1;
            state   <= SERVICE;
          end else if (!go) begin
            irq_req <= 1'b0;
            state   <= IDLE;
          end
        end
        SERVICE: begin
          if (flagwr && !gpu_din[IMASK_BIT]) begin
            imask <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Flags read mux; unused bits and a deselected read return zero
  always_comb begin
    flag_dout = '0;
    if (flagrd) begin
      flag_dout[IMASK_BIT]          = imask;
      flag_dout[EN_LSB +: NSRC]     = enable;
      flag_dout[CLR_LSB +: NSRC]    = latch;
    end
  end

endmodule
